// File: rtl/modexp_controller.sv
// Modular exponentiation sequencer: right-to-left square-and-multiply driving
// external square-mod and multiply-mod units through a start/valid handshake.
module modexp_controller #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ready_in,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [WIDTH-1:0]     modulus_in,
  input  logic [EXP_WIDTH-1:0] exponent_in,
  output logic [WIDTH-1:0]     result_out,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic                 sq_ready_out,
  output logic [WIDTH-1:0]     sq_value_out,
  output logic [WIDTH-1:0]     sq_modulus_out,
  input  logic [WIDTH-1:0]     sq_result_in,
  input  logic                 sq_valid_in,
  output logic                 mul_ready_out,
  output logic [WIDTH-1:0]     mul_a_out,
  output logic [WIDTH-1:0]     mul_b_out,
  output logic [WIDTH-1:0]     mul_modulus_out,
  input  logic [WIDTH-1:0]     mul_result_in,
  input  logic                 mul_valid_in
);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE_ISSUE,
    REDUCE_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    SQ_ISSUE,
    SQ_WAIT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]     base_r;
  logic [WIDTH-1:0]     acc_r;
  logic [WIDTH-1:0]     mod_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [EXP_WIDTH-1:0] exp_shifted;
  logic                 err_r;
  logic                 trivial_start;

  assign exp_shifted   = exp_r >> 1;
  assign trivial_start = (modulus_in <= WIDTH'(1)) || (exponent_in == '0);

  // Decide what the current low exponent bit asks for next.
  function automatic state_t bit_step(input logic [EXP_WIDTH-1:0] e);
    if (e[0])
      return MUL_ISSUE;
    else if ((e >> 1) != '0)
      return SQ_ISSUE;
    else
      return DONE;
  endfunction

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (ready_in) state_next = trivial_start ? DONE : REDUCE_ISSUE;
      REDUCE_ISSUE: state_next = REDUCE_WAIT;
      REDUCE_WAIT:  if (mul_valid_in) state_next = bit_step(exp_r);
      MUL_ISSUE:    state_next = MUL_WAIT;
      MUL_WAIT:     if (mul_valid_in) state_next = (exp_shifted != '0) ? SQ_ISSUE : DONE;
      SQ_ISSUE:     state_next = SQ_WAIT;
      SQ_WAIT:      if (sq_valid_in) state_next = bit_step(exp_shifted);
      DONE:         state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // acc starts at 1, so the reduction step is simply mul(acc, base); for
  // modulus 0 or 1 it starts at 0 and is reported unchanged.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      base_r     <= '0;
      acc_r      <= '0;
      mod_r      <= '0;
      exp_r      <= '0;
      err_r      <= 1'b0;
      result_out <= '0;
      error_out  <= 1'b0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= (state == DONE);
      case (state)
        IDLE: begin
          if (ready_in) begin
            base_r <= base_in;
            exp_r  <= exponent_in;
            mod_r  <= modulus_in;
            err_r  <= (modulus_in == '0);
            acc_r  <= (modulus_in <= WIDTH'(1)) ? '0 : WIDTH'(1);
          end
        end
        REDUCE_WAIT: if (mul_valid_in) base_r <= mul_result_in;
        MUL_WAIT:    if (mul_valid_in) acc_r <= mul_result_in;
        SQ_WAIT: begin
          if (sq_valid_in) begin
            base_r <= sq_result_in;
            exp_r  <= exp_shifted;
          end
        end
        DONE: begin
          result_out <= acc_r;
          error_out  <= err_r;
        end
        default: ;
      endcase
    end
  end

  assign busy_out        = (state != IDLE);
  assign sq_ready_out    = (state == SQ_ISSUE);
  assign mul_ready_out   = (state == REDUCE_ISSUE) || (state == MUL_ISSUE);
  assign sq_value_out    = base_r;
  assign sq_modulus_out  = mod_r;
  assign mul_a_out       = acc_r;
  assign mul_b_out       = base_r;
  assign mul_modulus_out = mod_r;

endmodule

// File: tb/tb_modexp_controller.sv
// Self-checking bench for modexp_controller: behavioural square/multiply units
// with random latency, table vectors, random cases and hand-written corner sequences.
module tb_modexp_controller;

  localparam int W  = 16;
  localparam int EW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [W-1:0]  base_in = '0;
  logic [W-1:0]  modulus_in = '0;
  logic [EW-1:0] exponent_in = '0;
  logic [W-1:0]  result_out;
  logic          busy_out, valid_out, error_out;
  logic          sq_ready_out, sq_valid_in;
  logic [W-1:0]  sq_value_out, sq_modulus_out, sq_result_in;
  logic          mul_ready_out, mul_valid_in;
  logic [W-1:0]  mul_a_out, mul_b_out, mul_modulus_out, mul_result_in;

  modexp_controller #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ready_in(ready_in),
    .base_in(base_in), .modulus_in(modulus_in), .exponent_in(exponent_in),
    .result_out(result_out), .busy_out(busy_out), .valid_out(valid_out), .error_out(error_out),
    .sq_ready_out(sq_ready_out), .sq_value_out(sq_value_out), .sq_modulus_out(sq_modulus_out),
    .sq_result_in(sq_result_in), .sq_valid_in(sq_valid_in),
    .mul_ready_out(mul_ready_out), .mul_a_out(mul_a_out), .mul_b_out(mul_b_out),
    .mul_modulus_out(mul_modulus_out), .mul_result_in(mul_result_in), .mul_valid_in(mul_valid_in)
  );

  always #5 clk_in = ~clk_in;

  int n_checked = 0;
  int n_failed  = 0;
  int mul_pulses = 0;
  int sq_pulses  = 0;

  // Behavioural arithmetic units: latch operands on the start pulse, answer 1-5 cycles later.
  logic         mul_pend = 1'b0, sq_pend = 1'b0;
  int           mul_cnt = 0, sq_cnt = 0;
  logic         mul_valid_m = 1'b0, sq_valid_m = 1'b0;
  logic [W-1:0] mul_res_m = '0, sq_res_m = '0;
  logic         stray_sq = 1'b0;
  logic [W-1:0] stray_val = 16'hBEEF;

  assign mul_valid_in  = mul_valid_m;
  assign mul_result_in = mul_res_m;
  assign sq_valid_in   = sq_valid_m | stray_sq;
  assign sq_result_in  = stray_sq ? stray_val : sq_res_m;

  always @(negedge clk_in) begin
    mul_valid_m = 1'b0;
    sq_valid_m  = 1'b0;
    if (mul_pend) begin
      if (mul_cnt == 0) begin mul_valid_m = 1'b1; mul_pend = 1'b0; end
      else mul_cnt--;
    end
    if (sq_pend) begin
      if (sq_cnt == 0) begin sq_valid_m = 1'b1; sq_pend = 1'b0; end
      else sq_cnt--;
    end
    if (mul_ready_out) begin
      mul_pulses++;
      mul_pend = 1'b1;
      mul_cnt  = $urandom_range(0, 4);
      mul_res_m = (mul_modulus_out == '0) ? '0 :
        W'((longint'(mul_a_out) * longint'(mul_b_out)) % longint'(mul_modulus_out));
    end
    if (sq_ready_out) begin
      sq_pulses++;
      sq_pend = 1'b1;
      sq_cnt  = $urandom_range(0, 4);
      sq_res_m = (sq_modulus_out == '0) ? '0 :
        W'((longint'(sq_value_out) * longint'(sq_value_out)) % longint'(sq_modulus_out));
    end
  end

  typedef struct {
    logic [W-1:0]  b;
    logic [EW-1:0] e;
    logic [W-1:0]  m;
    logic [W-1:0]  res;
    logic          err;
    int            nm;
    int            ns;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checked++;
    if (act !== req) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: naive repeated multiplication, unit-call counts from the exponent's bits.
  function automatic vec_t ref_model(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] m);
    vec_t   v;
    longint acc;
    v.b = b; v.e = e; v.m = m;
    v.err = (m == '0);
    v.nm = 0;
    v.ns = 0;
    if (m == '0) begin
      v.res = '0;
    end else begin
      acc = 1 % longint'(m);
      for (int i = 0; i < int'(e); i++) acc = (acc * longint'(b)) % longint'(m);
      v.res = W'(acc);
    end
    if (m > 1 && e != '0) begin
      v.nm = 1 + $countones(e);
      for (int i = 0; i < EW; i++) if (e[i]) v.ns = i;
    end
    return v;
  endfunction

  task automatic apply_stimulus(input string name, input vec_t v, input bit disturb);
    int cycles;
    int mul_seen;
    bit arm;
    @(negedge clk_in);
    mul_pulses = 0;
    sq_pulses  = 0;
    base_in = v.b; exponent_in = v.e; modulus_in = v.m;
    ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    check_output({name, ".busy_after_start"}, busy_out, 1);
    base_in = W'($urandom); exponent_in = EW'($urandom); modulus_in = W'($urandom);
    cycles = 0; mul_seen = 0; arm = 0;
    while (!valid_out && cycles < 3000) begin
      if (disturb) ready_in = (cycles < 6);
      stray_sq = arm;
      arm = 0;
      if (mul_ready_out) begin
        mul_seen++;
        if (disturb && mul_seen == 2) arm = 1;
      end
      @(negedge clk_in);
      cycles++;
    end
    stray_sq = 1'b0;
    ready_in = 1'b0;
    if (cycles >= 3000) begin
      n_checked++;
      n_failed++;
      $display("[TB] FAIL %s.timeout: got no valid_out expected valid_out within 3000 cycles", name);
      return;
    end
    check_output({name, ".result"}, result_out, v.res);
    check_output({name, ".error"}, error_out, v.err);
    check_output({name, ".mul_pulses"}, mul_pulses, v.nm);
    check_output({name, ".sq_pulses"}, sq_pulses, v.ns);
    check_output({name, ".busy_at_valid"}, busy_out, 0);
    @(negedge clk_in);
    check_output({name, ".valid_single"}, valid_out, 0);
    check_output({name, ".result_held"}, result_out, v.res);
  endtask

  initial begin
    vec_t v;
    int   cycles;
    int   saw_busy, saw_valid;

    vecs[0] = '{b:3,  e:5,  m:7,    res:5,  err:0, nm:3, ns:2};
    vecs[1] = '{b:20, e:3,  m:7,    res:6,  err:0, nm:3, ns:1};
    vecs[2] = '{b:2,  e:10, m:1000, res:24, err:0, nm:3, ns:3};
    vecs[3] = '{b:9,  e:0,  m:13,   res:1,  err:0, nm:0, ns:0};
    vecs[4] = '{b:5,  e:7,  m:0,    res:0,  err:1, nm:0, ns:0};
    vecs[5] = '{b:5,  e:7,  m:1,    res:0,  err:0, nm:0, ns:0};

    repeat (3) @(negedge clk_in);
    check_output("reset.result", result_out, 0);
    check_output("reset.busy", busy_out, 0);
    check_output("reset.valid", valid_out, 0);
    check_output("reset.error", error_out, 0);
    check_output("reset.unit_starts", {sq_ready_out, mul_ready_out}, 0);
    check_output("reset.operands", sq_value_out | mul_a_out | mul_modulus_out, 0);
    rst_in = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus($sformatf("vec%0d", i), vecs[i], 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0]  rb, rm;
      logic [EW-1:0] re;
      rb = W'($urandom);
      re = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 15)) : EW'($urandom);
      rm = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      v = ref_model(rb, re, rm);
      apply_stimulus($sformatf("rand%0d", i), v, 1'b0);
    end

    // ready_in while busy and a stray sq_valid_in during MUL_WAIT must not disturb the result.
    apply_stimulus("disturb", vecs[0], 1'b1);
    repeat (3) @(negedge clk_in);
    check_output("disturb.no_restart", busy_out, 0);

    // Reset in the middle of SQ_WAIT, then a late square result after release.
    @(negedge clk_in);
    base_in = 3; exponent_in = 5; modulus_in = 7; ready_in = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    cycles = 0;
    while (!sq_ready_out && cycles < 500) begin
      @(negedge clk_in);
      cycles++;
    end
    check_output("rstwait.reached_sq_issue", sq_ready_out, 1);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check_output("rstwait.result", result_out, 0);
    check_output("rstwait.busy", busy_out, 0);
    check_output("rstwait.valid_error", {valid_out, error_out}, 0);
    check_output("rstwait.unit_starts", {sq_ready_out, mul_ready_out}, 0);
    check_output("rstwait.operands", sq_value_out | mul_a_out | sq_modulus_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    stray_sq = 1'b1;
    @(negedge clk_in);
    stray_sq = 1'b0;
    saw_busy = 0; saw_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_out) saw_busy++;
      if (valid_out) saw_valid++;
      @(negedge clk_in);
    end
    check_output("rstwait.late_valid_busy", saw_busy, 0);
    check_output("rstwait.late_valid_pulse", saw_valid, 0);
    apply_stimulus("after_reset", vecs[2], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule

// File: doc/modexp_controller.md
MODEXP_CONTROLLER -- requirements
Module: modexp_controller

Interface
REQ-001 Parameter WIDTH, default 16, operand/modulus/result width in bits.
REQ-002 Parameter EXP_WIDTH, default 16, exponent width in bits.
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-low.
REQ-005 ready_in  input  1  start request, sampled only in IDLE.
REQ-006 base_in, modulus_in  input  WIDTH each  operands, latched on accepted start.
REQ-007 exponent_in  input  EXP_WIDTH  exponent, latched on accepted start.
REQ-008 result_out  output  WIDTH  base^exponent mod modulus, registered, held until next completion.
REQ-009 busy_out  output  1  high from cycle after accepted start until completion.
REQ-010 valid_out  output  1  one-cycle completion pulse.
REQ-011 error_out  output  1  registered, high with valid_out when latched modulus was 0.
REQ-012 sq_ready_out  output  1  one-cycle start pulse to the external square-mod unit.
REQ-013 sq_value_out, sq_modulus_out  output  WIDTH each  square-unit operands.
REQ-014 sq_result_in  input  WIDTH, sq_valid_in  input  1  square-unit result and completion strobe.
REQ-015 mul_ready_out  output  1  one-cycle start pulse to the external multiply-mod unit.
REQ-016 mul_a_out, mul_b_out, mul_modulus_out  output  WIDTH each  multiply-unit operands.
REQ-017 mul_result_in  input  WIDTH, mul_valid_in  input  1  multiply-unit result and completion strobe.

Function
REQ-018 States SHALL be IDLE, REDUCE_ISSUE, REDUCE_WAIT, MUL_ISSUE, MUL_WAIT, SQ_ISSUE, SQ_WAIT, DONE.
REQ-019 IDLE with ready_in=1 SHALL latch base, exponent, modulus, set acc=1, and assert busy_out next cycle; ready_in SHALL be ignored in every other state.
REQ-020 Modulus 0 SHALL go directly to DONE with error_out=1 and result_out=0; no unit SHALL be started.
REQ-021 Modulus 1 SHALL go directly to DONE with result_out=0 and error_out=0.
REQ-022 Otherwise REDUCE SHALL run mul(1, base) so the working base b = base mod modulus.
REQ-023 Bit loop, LSB first: if exponent bit set, run mul(acc, b) and store result in acc; if any higher set bit remains, run sq(b) and store result in b, then shift exponent right; else go to DONE.
REQ-024 Exponent 0 SHALL skip REDUCE and the bit loop and finish with result_out=1.
REQ-025 Each *_ISSUE state SHALL last one cycle and pulse the matching *_ready_out exactly once; the next state SHALL be the matching *_WAIT.
REQ-026 Operand outputs SHALL be stable from the ISSUE cycle until the corresponding *_valid_in is sampled.
REQ-027 *_WAIT SHALL capture *_result_in in the cycle *_valid_in=1; there SHALL be no timeout.
REQ-028 *_valid_in asserted outside its matching WAIT state SHALL be ignored.
REQ-029 DONE SHALL last one cycle: register result_out and error_out, pulse valid_out, deassert busy_out, and return to IDLE.
REQ-030 ready_in=1 in the DONE cycle SHALL be ignored; ready_in=1 in the following IDLE cycle SHALL be accepted.
REQ-031 Unit-call count: exactly 1 + popcount(exponent) multiplies and (index of highest set bit) squares.

Reset
REQ-032 rst_in=0 SHALL immediately force state IDLE, result_out=0, busy_out=0, valid_out=0, error_out=0, sq_ready_out=0, mul_ready_out=0, and clear all operand registers.
REQ-033 Reset during any WAIT state SHALL abandon the operation; a late *_valid_in after reset release SHALL be ignored.

Verification
REQ-034 Start with base=3, exponent=5, modulus=7 and behavioural units of random latency -> result_out=5, 3 mul pulses, 2 sq pulses, single valid_out.
REQ-035 Start with base=20, exponent=3, modulus=7 -> REDUCE yields b=6, result_out=6.
REQ-036 Start with base=2, exponent=10, modulus=1000 -> result_out=24; start with base=9, exponent=0, modulus=13 -> result_out=1 with no unit pulses.
REQ-037 Start with modulus=0 -> error_out=1, result_out=0, no unit pulses; start with modulus=1 -> result_out=0, error_out=0.
REQ-038 Pulse ready_in while busy, inject a stray sq_valid_in during MUL_WAIT, and assert reset mid-SQ_WAIT -> the result is unaffected by the first two, and after reset all outputs are 0 and the next start computes correctly.
